booth_seq_mult8: RTL
====================

Name: booth_seq_mult8

Overview:
Sequential radix-2 Booth multiplier for two signed 8-bit operands, producing a 16-bit signed product.
- Sits directly upstream of the 8-bit carry-lookahead carry block: each add/subtract step drives that block's P/G/cin inputs and consumes its carry[8:0].
- One add/subtract step and one arithmetic shift per multiplier bit; start/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 8, operand width; only 8 is legal (it matches the 8-bit lookahead block); any other value is an elaboration error.
- CNT_W, 4, width of the iteration counter; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only when ready=1
- multiplicand  input  8  signed M, sampled on acceptance
- multiplier  input  8  signed Q, sampled on acceptance
- ready  output  1  high in IDLE
- busy  output  1  high in ADD, SHIFT, DONE
- done  output  1  one-cycle pulse when product is valid
- product  output  16  signed result, held until the next acceptance

Behaviour:
- One clock; reset is synchronous and active-low. When rst_n=0 at a clk edge:
  - state=IDLE; A, Q, q_1, M, count and product all clear to 0.
  - done=0, busy=0, ready=1.
- Registers:
  - A: 9 bits, signed accumulator (one guard bit).
  - Q: 8 bits.
  - q_1: 1 bit.
  - M: 9 bits, sign-extended multiplicand.
  - count: CNT_W bits.
- IDLE:
  - If start=1, latch M, Q, A=0, q_1=0, count=WIDTH, then go to ADD.
  - If start=0, stay in IDLE.
- ADD: one cycle. Decode {Q[0],q_1}:
  - 01: A = A + M
  - 10: A = A - M, computed as A + ~M with cin=1
  - 00 or 11: A unchanged, cin=0
  - Then go to SHIFT.
- Adder for the ADD step:
  - B = M or ~M (9 bits).
  - P = A[7:0]^B[7:0], G = A[7:0]&B[7:0].
  - sum[7:0] = P ^ carry[7:0].
  - Guard bit: sum[8] = A[8] ^ B[8] ^ carry[8].
  - No overflow is possible at 9 bits, including M = -128.
- SHIFT: one cycle.
  - Arithmetic right shift of {A,Q,q_1}: A[8] is replicated, A[0] goes to Q[7], Q[0] goes to q_1.
  - count decrements.
  - If the decremented count is 0, go to DONE; otherwise go to ADD.
- DONE: one cycle.
  - product = {A[7:0],Q}; done=1; then go to IDLE.
  - A[8] equals A[7] at this point; it is dropped.
- Latency:
  - Start is accepted at edge 0; done is high during cycle 2*WIDTH+1 = 17.
  - ready returns to 1 in cycle 18.
  - Back-to-back throughput: one product per 18 cycles.
- Handshake:
  - start while busy is ignored, with no queuing; operand inputs are don't-care outside acceptance.
  - start in the same cycle that done=1 is also ignored (ready=0 then).
- product stays stable from DONE until the next acceptance, and is not cleared on acceptance.
- Reset mid-operation: abort on the next edge with rst_n=0. No done pulse; product reads 0.
- busy = (state != IDLE); ready = (state == IDLE). Both are registered-state decodes, glitch-free.

Decomposition:
- Package booth_pkg:
  - WIDTH=8, CNT_W=4.
  - State enum IDLE/ADD/SHIFT/DONE (2-bit encoding).
  - Booth decode constants: BOOTH_NOP, BOOTH_ADD, BOOTH_SUB.
- Sub-module cla_add8, the one natural split:
  - Inputs: a[7:0], b[7:0], cin.
  - Forms P/G, instantiates the existing 8-bit lookahead carry block, outputs sum[7:0] and cout.
  - The top level adds the guard-bit XOR.

Test Plan:
- Reset then 3*5: start with M=3, Q=5 -> done in cycle 17, product=0x000F; ready=1 in cycle 18.
- Negative operand: M=-7 (0xF9), Q=6 -> product=0xFFD6 (-42).
- Guard-bit corner: M=-128, Q=-128 -> 0x4000; M=127, Q=-128 -> 0xC080; M=-128, Q=127 -> 0xC080.
- Zero and identity: M=0, Q=-1 -> 0x0000; M=-1, Q=-1 -> 0x0001; M=85, Q=1 -> 0x0055.
- start held high throughout with operands changed mid-operation -> first product unaffected; done pulses exactly once per 18 cycles; second result matches the operands present at the ready=1 edge.
- rst_n=0 for one edge at cycle 8 of an operation -> no done pulse, product=0x0000, ready=1 next cycle; a following 2*3 gives 0x0006.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cla_add8.sv
// 8-bit adder built on the lookahead carry block; exposes carry-out for the
// caller's guard-bit extension.
module cla_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] carry;

  assign p = a ^ b;
  assign g = a & b;

  cla_carry8 u_carry (
    .p     (p),
    .g     (g),
    .cin   (cin),
    .carry (carry)
  );

  assign sum  = p ^ carry[7:0];
  assign cout = carry[8];

endmodule

// File: rtl/cla_carry8.sv
// 8-bit carry-lookahead carry block: carry[i+1] from P/G and cin, each carry
// expanded as a flat sum of generate terms rather than a ripple chain.
module cla_carry8 (
  input  logic [7:0] p,
  input  logic [7:0] g,
  input  logic       cin,
  output logic [8:0] carry
);

  logic acc;
  logic prop;

  always_comb begin
    carry = '0;
    acc   = 1'b0;
    prop  = 1'b1;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      carry[i+1] = acc | (prop & cin);
    end
  end

endmodule

// File: rtl/booth_seq_mult8.sv
// Sequential radix-2 Booth multiplier: signed 8x8 -> 16, one add step and one
// arithmetic shift per multiplier bit, start/done handshake.
module booth_seq_mult8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import booth_pkg::*;

  // The adder is tied to the 8-bit lookahead block, so no other width exists.
  if (WIDTH != 8) begin : g_bad_width
    $error("booth_seq_mult8: WIDTH must be 8");
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("booth_seq_mult8: CNT_W too narrow to hold WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q;
  logic [WIDTH:0]     m_q;
  logic [WIDTH-1:0]   q_q;
  logic               q_1_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   cnt_dec;

  booth_op_e          op;
  logic [WIDTH:0]     b9;
  logic               cin;
  logic [7:0]         sum_lo;
  logic               cout;
  logic [WIDTH:0]     sum9;

  assign cnt_dec = count_q - CNT_W'(1);

  // Booth step operand select: +M, ~M with cin=1 for -M, or zero for no-op.
  always_comb begin
    op  = booth_decode(q_q[0], q_1_q);
    b9  = '0;
    cin = 1'b0;
    case (op)
      BOOTH_ADD: b9 = m_q;
      BOOTH_SUB: begin
        b9  = ~m_q;
        cin = 1'b1;
      end
      default: b9 = '0;
    endcase
  end

  cla_add8 u_add (
    .a    (a_q[7:0]),
    .b    (b9[7:0]),
    .cin  (cin),
    .sum  (sum_lo),
    .cout (cout)
  );

  assign sum9 = {a_q[WIDTH] ^ b9[WIDTH] ^ cout, sum_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = (cnt_dec == '0) ? DONE : ADD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath; product is captured on the final shift so it is valid with done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q_1_q   <= 1'b0;
      count_q <= '0;
      product <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= {multiplicand[WIDTH-1], multiplicand};
            q_q     <= multiplier;
            a_q     <= '0;
            q_1_q   <= 1'b0;
            count_q <= CNT_W'(WIDTH);
          end
        end
        ADD: a_q <= sum9;
        SHIFT: begin
          a_q     <= {a_q[WIDTH], a_q[WIDTH:1]};
          q_q     <= {a_q[0], q_q[WIDTH-1:1]};
          q_1_q   <= q_q[0];
          count_q <= cnt_dec;
          if (cnt_dec == '0) begin
            product <= {a_q[WIDTH:0], q_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule
